// File: rtl/fetch_hazard_ctrl_pkg.sv
// Shared decode constants and FSM state type for the front-end sequencing controller.
package pipeline_ctrl_pkg;

  // Instruction op field encodings
  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_MEM  = 2'b01;
  localparam logic [1:0] OP_CTRL = 2'b10;

  // Instruction inst field encodings
  localparam logic [1:0] INST_LD  = 2'b00;
  localparam logic [1:0] INST_ST  = 2'b01;
  localparam logic [1:0] INST_NOP = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    VEC_WAIT = 2'd1,
    FLUSH    = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/fetch_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: a scalar load in EX whose destination feeds
// the instruction waiting in IF/ID. R0 is hardwired zero and a NOP reads nothing.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       i_ex_is_ld,
  input  logic [3:0] i_ex_rd,
  input  logic [1:0] i_id_op,
  input  logic [1:0] i_id_inst,
  input  logic [3:0] i_id_rs_a,
  input  logic [3:0] i_id_rs_b,
  output logic       o_hazard
);

  logic w_id_is_nop;
  logic w_rd_nonzero;
  logic w_rd_match;

  assign w_id_is_nop  = (i_id_op == OP_ALU) && (i_id_inst == INST_NOP);
  assign w_rd_nonzero = (i_ex_rd != 4'd0);
  assign w_rd_match   = (i_ex_rd == i_id_rs_a) || (i_ex_rd == i_id_rs_b);

  assign o_hazard = i_ex_is_ld && w_rd_nonzero && w_rd_match && !w_id_is_nop;

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Front-end sequencing controller: decides each cycle whether PC, IF/ID and ID/EX
// advance, stall, take a bubble or flush, and profiles stalled cycles.
module fetch_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int VEC_BEATS    = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int PERF_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        id_op,
  input  logic [1:0]        id_inst,
  input  logic [3:0]        id_rs_a,
  input  logic [3:0]        id_rs_b,
  input  logic              ex_valid,
  input  logic [1:0]        ex_op,
  input  logic [1:0]        ex_inst,
  input  logic              ex_flagV,
  input  logic [3:0]        ex_rd,
  input  logic              jmp_en,
  output logic              pc_en,
  output logic              pc_sel_jmp,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              ex_hold,
  output logic [1:0]        state_o,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int VC_W = (VEC_BEATS > 1) ? $clog2(VEC_BEATS) : 1;
  // The RUN cycle that sees the vector op is the first hold beat, so VEC_WAIT covers the rest.
  localparam logic [VC_W-1:0] VEC_RELOAD   = VC_W'(VEC_BEATS - 2);
  // The jump cycle is the first flush beat; FLUSH covers the remaining ones.
  localparam logic [1:0]      FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  ctrl_state_t       r_state;
  logic [VC_W-1:0]   r_vec_cnt;
  logic [1:0]        r_flush_cnt;
  logic [PERF_W-1:0] r_stall_cycles;

  logic w_scalar_ld;
  logic w_vec_mem;
  logic w_load_use;

  assign w_scalar_ld = ex_valid && (ex_op == OP_MEM) && (ex_inst == INST_LD) && !ex_flagV;
  assign w_vec_mem   = ex_valid && (ex_op == OP_MEM) && ex_flagV;

  load_use_detect u_load_use_detect (
    .i_ex_is_ld (w_scalar_ld),
    .i_ex_rd    (ex_rd),
    .i_id_op    (id_op),
    .i_id_inst  (id_inst),
    .i_id_rs_a  (id_rs_a),
    .i_id_rs_b  (id_rs_b),
    .o_hazard   (w_load_use)
  );

  // Output decode from current state and inputs; reset forces a quiet, flushing front end
  always_comb begin
    pc_en      = 1'b0;
    pc_sel_jmp = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    ex_hold    = 1'b0;
    if (rst) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (jmp_en) begin
            pc_en      = 1'b1;
            pc_sel_jmp = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (w_vec_mem) begin
            ex_hold = 1'b1;
          end else if (w_load_use) begin
            idex_flush = 1'b1;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end
        end
        VEC_WAIT: begin
          ex_hold = 1'b1;
        end
        FLUSH: begin
          pc_en      = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
        default: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
      endcase
    end
  end

  // FSM, beat counters and saturating stall profiler
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= RUN;
      r_vec_cnt      <= '0;
      r_flush_cnt    <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (!pc_en && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      case (r_state)
        RUN: begin
          if (jmp_en) begin
            if (FLUSH_CYCLES > 1) begin
              r_state     <= FLUSH;
              r_flush_cnt <= FLUSH_RELOAD;
            end
          end else if (w_vec_mem) begin
            r_state   <= VEC_WAIT;
            r_vec_cnt <= VEC_RELOAD;
          end
        end
        VEC_WAIT: begin
          if (r_vec_cnt == '0) begin
            r_state <= RUN;
          end else begin
            r_vec_cnt <= r_vec_cnt - 1'b1;
          end
        end
        FLUSH: begin
          // r_flush_cnt counts remaining flush beats including this one; leave as it hits 0
          if (r_flush_cnt <= 2'd1) begin
            r_state <= RUN;
          end
          if (r_flush_cnt != 2'd0) begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  // EX is frozen during VEC_WAIT, so a jump cannot legitimately resolve there
  always_ff @(posedge clk) begin
    if (!rst && (r_state == VEC_WAIT)) begin
      assert (!jmp_en);
    end
  end

  assign state_o      = r_state;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Directed-vector bench for fetch_hazard_ctrl (VEC_BEATS=4, FLUSH_CYCLES=2, PERF_W=16).
module tb_fetch_hazard_ctrl;
  import pipeline_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  id_op, id_inst;
  logic [3:0]  id_rs_a, id_rs_b;
  logic        ex_valid;
  logic [1:0]  ex_op, ex_inst;
  logic        ex_flagV;
  logic [3:0]  ex_rd;
  logic        jmp_en;
  logic        pc_en, pc_sel_jmp, ifid_en, ifid_flush, idex_flush, ex_hold;
  logic [1:0]  state_o;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  // {pc_en, pc_sel_jmp, ifid_en, ifid_flush, idex_flush, ex_hold}
  logic [5:0] ctl;
  assign ctl = {pc_en, pc_sel_jmp, ifid_en, ifid_flush, idex_flush, ex_hold};

  localparam logic [5:0] C_RST = 6'b000110;
  localparam logic [5:0] C_RUN = 6'b101000;
  localparam logic [5:0] C_LU  = 6'b000010;
  localparam logic [5:0] C_VEC = 6'b000001;
  localparam logic [5:0] C_JMP = 6'b110110;
  localparam logic [5:0] C_FL  = 6'b100110;

  always #5 clk = ~clk;

  fetch_hazard_ctrl #(
    .VEC_BEATS    (4),
    .FLUSH_CYCLES (2),
    .PERF_W       (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_op        (id_op),
    .id_inst      (id_inst),
    .id_rs_a      (id_rs_a),
    .id_rs_b      (id_rs_b),
    .ex_valid     (ex_valid),
    .ex_op        (ex_op),
    .ex_inst      (ex_inst),
    .ex_flagV     (ex_flagV),
    .ex_rd        (ex_rd),
    .jmp_en       (jmp_en),
    .pc_en        (pc_en),
    .pc_sel_jmp   (pc_sel_jmp),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .ex_hold      (ex_hold),
    .state_o      (state_o),
    .stall_cycles (stall_cycles)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_op    = OP_ALU;
    id_inst  = 2'b11;
    id_rs_a  = 4'd1;
    id_rs_b  = 4'd2;
    ex_valid = 1'b0;
    ex_op    = OP_ALU;
    ex_inst  = 2'b11;
    ex_flagV = 1'b0;
    ex_rd    = 4'd0;
    jmp_en   = 1'b0;
  endtask

  task automatic set_ex_ld(input logic [3:0] rd);
    ex_valid = 1'b1;
    ex_op    = OP_MEM;
    ex_inst  = INST_LD;
    ex_flagV = 1'b0;
    ex_rd    = rd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    #1;
    total++; if (ctl !== C_RST) begin bad++; $display("FAIL reset_ctl_c1 got=%b want=%b", ctl, C_RST); end
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL reset_stall got=%0d want=0", stall_cycles); end
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_o); end
    step();
    #1;
    total++; if (ctl !== C_RST) begin bad++; $display("FAIL reset_ctl_c2 got=%b want=%b", ctl, C_RST); end
    rst = 1'b0;
    #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL release_ctl got=%b want=%b", ctl, C_RUN); end
    step();
    #1;
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL release_stall got=%0d want=0", stall_cycles); end
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL release_ctl2 got=%b want=%b", ctl, C_RUN); end
  endtask

  task automatic test_load_use();
    set_ex_ld(4'd5);
    id_rs_a = 4'd5;
    #1;
    total++; if (ctl !== C_LU) begin bad++; $display("FAIL lu_rs_a_ctl got=%b want=%b", ctl, C_LU); end
    step();
    ex_valid = 1'b0;
    #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL lu_bubble_ctl got=%b want=%b", ctl, C_RUN); end
    total++; if (stall_cycles !== 16'd1) begin bad++; $display("FAIL lu_stall1 got=%0d want=1", stall_cycles); end
    step();
    #1;
    total++; if (stall_cycles !== 16'd1) begin bad++; $display("FAIL lu_stall_hold got=%0d want=1", stall_cycles); end
    set_ex_ld(4'd0);
    id_rs_a = 4'd0;
    #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL lu_r0_ctl got=%b want=%b", ctl, C_RUN); end
    step();
    idle_inputs();
    set_ex_ld(4'd7);
    id_rs_b = 4'd7;
    #1;
    total++; if (ctl !== C_LU) begin bad++; $display("FAIL lu_rs_b_ctl got=%b want=%b", ctl, C_LU); end
    step();
    idle_inputs();
    #1;
    total++; if (stall_cycles !== 16'd2) begin bad++; $display("FAIL lu_stall2 got=%0d want=2", stall_cycles); end
    set_ex_ld(4'd4);
    id_rs_a = 4'd4;
    id_op   = OP_ALU;
    id_inst = INST_NOP;
    #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL lu_nop_ctl got=%b want=%b", ctl, C_RUN); end
    step();
    idle_inputs();
    #1;
    total++; if (stall_cycles !== 16'd2) begin bad++; $display("FAIL lu_nop_stall got=%0d want=2", stall_cycles); end
  endtask

  task automatic test_vector();
    do_reset();
    ex_valid = 1'b1;
    ex_op    = OP_MEM;
    ex_inst  = INST_LD;
    ex_flagV = 1'b1;
    ex_rd    = 4'd6;
    id_rs_a  = 4'd6;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (ctl !== C_VEC) begin bad++; $display("FAIL vec_hold_%0d got=%b want=%b", i, ctl, C_VEC); end
      total++; if (state_o !== ((i == 0) ? 2'd0 : 2'd1)) begin bad++; $display("FAIL vec_state_%0d got=%0d want=%0d", i, state_o, (i == 0) ? 0 : 1); end
      step();
    end
    idle_inputs();
    #1;
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL vec_exit_state got=%0d want=0", state_o); end
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL vec_exit_ctl got=%b want=%b", ctl, C_RUN); end
    total++; if (stall_cycles !== 16'd4) begin bad++; $display("FAIL vec_stall got=%0d want=4", stall_cycles); end
    ex_valid = 1'b1;
    ex_op    = OP_MEM;
    ex_inst  = INST_ST;
    ex_flagV = 1'b1;
    #1;
    total++; if (ctl !== C_VEC) begin bad++; $display("FAIL vst_ctl got=%b want=%b", ctl, C_VEC); end
    repeat (4) step();
    idle_inputs();
    #1;
    total++; if (stall_cycles !== 16'd8) begin bad++; $display("FAIL vst_stall got=%0d want=8", stall_cycles); end
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL vst_exit_ctl got=%b want=%b", ctl, C_RUN); end
  endtask

  task automatic test_jump();
    do_reset();
    set_ex_ld(4'd5);
    id_rs_a = 4'd5;
    jmp_en  = 1'b1;
    #1;
    total++; if (ctl !== C_JMP) begin bad++; $display("FAIL jmp_ctl got=%b want=%b", ctl, C_JMP); end
    step();
    idle_inputs();
    #1;
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL jmp_flush_state got=%0d want=2", state_o); end
    total++; if (ctl !== C_FL) begin bad++; $display("FAIL jmp_flush_ctl got=%b want=%b", ctl, C_FL); end
    step();
    #1;
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL jmp_exit_state got=%0d want=0", state_o); end
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL jmp_exit_ctl got=%b want=%b", ctl, C_RUN); end
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL jmp_stall got=%0d want=0", stall_cycles); end
  endtask

  task automatic test_reset_mid_vec();
    do_reset();
    ex_valid = 1'b1;
    ex_op    = OP_MEM;
    ex_inst  = INST_LD;
    ex_flagV = 1'b1;
    step();
    step();
    #1;
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL midvec_state got=%0d want=1", state_o); end
    total++; if (stall_cycles !== 16'd2) begin bad++; $display("FAIL midvec_stall got=%0d want=2", stall_cycles); end
    rst = 1'b1;
    #1;
    total++; if (ctl !== C_RST) begin bad++; $display("FAIL midvec_rst_ctl got=%b want=%b", ctl, C_RST); end
    step();
    rst = 1'b0;
    idle_inputs();
    #1;
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL midvec_post_state got=%0d want=0", state_o); end
    total++; if (ex_hold !== 1'b0) begin bad++; $display("FAIL midvec_post_hold got=%b want=0", ex_hold); end
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL midvec_post_stall got=%0d want=0", stall_cycles); end
  endtask

  task automatic test_saturate();
    do_reset();
    set_ex_ld(4'd3);
    id_rs_a = 4'd3;
    repeat (65534) step();
    #1;
    total++; if (stall_cycles !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h want=fffe", stall_cycles); end
    step();
    #1;
    total++; if (stall_cycles !== 16'hFFFF) begin bad++; $display("FAIL sat_hit got=%h want=ffff", stall_cycles); end
    repeat (4465) step();
    #1;
    total++; if (stall_cycles !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h want=ffff", stall_cycles); end
    total++; if (ctl !== C_LU) begin bad++; $display("FAIL sat_ctl got=%b want=%b", ctl, C_LU); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_vector();
    test_jump();
    test_reset_mid_vec();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
